// File: rtl/psum_accumulator_if.sv
// Partial-sum accumulator handshake bundle: psum input beats, clear control, result FIFO head.
// The master modport drives beats and outReady; the slave modport is the accumulator itself.
interface psum_accumulator_if #(
  parameter int W = 16,
  parameter int A = 7
);
  logic [W-1:0] psumIn;
  logic [A-1:0] psumAddr;
  logic         psumValid;
  logic         psumFirst;
  logic         psumLast;
  logic         reluEn;
  logic         psumReady;
  logic         clearStart;
  logic         busy;
  logic [W-1:0] outData;
  logic [A-1:0] outAddr;
  logic         outValid;
  logic         outReady;
  logic [2:0]   fifoCount;

  modport master (
    output psumIn, psumAddr, psumValid, psumFirst, psumLast, reluEn, clearStart, outReady,
    input  psumReady, busy, outData, outAddr, outValid, fifoCount
  );

  modport slave (
    input  psumIn, psumAddr, psumValid, psumFirst, psumLast, reluEn, clearStart, outReady,
    output psumReady, busy, outData, outAddr, outValid, fifoCount
  );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates column partial sums per neuron index; last pass emits ReLU'd result one cycle later via a 4-deep FIFO.
// Beats stall while the FIFO is full (registered count, no pop bypass) or a buffer clear sweep runs.
module psum_accumulator #(
  parameter int W = 16,
  parameter int A = 7
) (
  input  logic               CLK,
  input  logic               RSTn,
  psum_accumulator_if.slave  bus
);
  localparam int DEPTH = 1 << A;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             clearing;
  logic [A-1:0]     clr_addr;

  logic [W-1:0]     acc_buf [DEPTH];
  logic [W-1:0]     sum;
  logic [W-1:0]     res;
  logic             ready;
  logic             accept;
  logic             push;
  logic             pop;

  logic [A+W-1:0]   fifo_mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic [A+W-1:0]   head;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clearStart) state_nxt = CLEAR;
      CLEAR:   if (clr_addr == '1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clearing = (state == CLEAR);
  end

  // Counter wraps back to 0 on the final write, ready for the next sweep.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)         clr_addr <= '0;
    else if (clearing) clr_addr <= clr_addr + A'(1);
  end

  // Ready deliberately ignores outReady so a pop never opens a full FIFO in the same cycle.
  assign ready  = !clearing && !bus.clearStart && (count < 3'd4);
  assign accept = bus.psumValid && ready;
  assign sum    = bus.psumFirst ? bus.psumIn : acc_buf[bus.psumAddr] + bus.psumIn;
  assign res    = (bus.reluEn && sum[W-1]) ? '0 : sum;
  assign push   = accept && bus.psumLast;
  assign pop    = (count != 3'd0) && bus.outReady;

  always_ff @(posedge CLK) begin
    if (clearing)    acc_buf[clr_addr] <= '0;
    else if (accept) acc_buf[bus.psumAddr] <= sum;
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {bus.psumAddr, res};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  // Head is masked while empty so the outputs read zero out of reset.
  assign head          = fifo_mem[rd_ptr];
  assign bus.outValid  = (count != 3'd0);
  assign bus.outData   = bus.outValid ? head[W-1:0] : '0;
  assign bus.outAddr   = bus.outValid ? head[A+W-1:W] : '0;
  assign bus.fifoCount = count;
  assign bus.psumReady = ready;
  assign bus.busy      = clearing;
endmodule
